net_monitor: RTL and testbench
==============================

NET_MONITOR -- requirements
Module: net_monitor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on din (legal range 2..4).
REQ-002 SHALL have parameter CNT_W, default 16, width of the edge counter.
REQ-003 SHALL have parameter STUCK_CYCLES, default 1000, edge-free cycles before stuck is flagged (>=2).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port din  input  1  monitored net from the driving module; asynchronous to clk.
REQ-008 SHALL have port expect  input  1  expected steady level of din.
REQ-009 SHALL have port clear  input  1  zeroes the counter and the stuck timer.
REQ-010 SHALL have port level  output  1  synchronized din.
REQ-011 SHALL have port rise  output  1  one-cycle pulse on a 0->1 change of level.
REQ-012 SHALL have port fall  output  1  one-cycle pulse on a 1->0 change of level.
REQ-013 SHALL have port edge_cnt  output  CNT_W  number of rise+fall events.
REQ-014 SHALL have port mismatch  output  1  registered flag for level != expect.
REQ-015 SHALL have port stuck  output  1  no edge seen for STUCK_CYCLES cycles.
REQ-016 SHALL have port state  output  2  current FSM state.

Function
REQ-017 SHALL pass din through SYNC_STAGES flops; level is the last stage, so a din change stable before edge k appears on level after edge k+SYNC_STAGES-1.
REQ-018 SHALL register rise/fall by comparing level with its previous value; each pulse lasts exactly one cycle, in the cycle after level changes.
REQ-019 SHALL implement FSM states WARMUP(0), TRACK(1), STUCK(2); encoding 3 is illegal and SHALL recover to WARMUP on the next edge.
REQ-020 SHALL remain in WARMUP for SYNC_STAGES+1 cycles after reset deassertion, then enter TRACK; in WARMUP, rise, fall, mismatch and count updates are suppressed, so the initial level is never counted as an edge.
REQ-021 SHALL increment edge_cnt on each rise or fall in TRACK/STUCK and saturate at all-ones with no wrap.
REQ-022 SHALL give clear priority over a same-cycle edge: edge_cnt is 0 on the next cycle.
REQ-023 SHALL hold a stuck timer that resets on any edge or clear and increments every TRACK cycle; when it reaches STUCK_CYCLES-1 the FSM enters STUCK and stuck=1 on the next cycle.
REQ-024 SHALL in STUCK, on an edge or clear, return to TRACK, clear stuck and reset the timer on the next cycle; an edge also counts.
REQ-025 SHALL register mismatch = (level != expect) each cycle in TRACK/STUCK.
REQ-026 SHALL compile and behave identically under `default_nettype none; every net is explicitly declared.

Reset
REQ-027 SHALL on rst=1, at the next edge, force sync flops, level, rise, fall, mismatch and stuck to 0, edge_cnt to 0, the timer to 0 and state to WARMUP, regardless of operation in progress.
REQ-028 SHALL restart the full WARMUP period when rst is asserted mid-operation.

Configuration
REQ-029 SHALL with NET_MONITOR_STUCK_EN defined implement the stuck timer, the STUCK state and the stuck output as specified.
REQ-030 SHALL with NET_MONITOR_STUCK_EN undefined omit the timer, tie stuck to 0 and never enter STUCK; all other behaviour is unchanged.

Structure
REQ-031 SHALL place state encodings (ST_WARMUP, ST_TRACK, ST_STUCK) and the width constant STATE_W=2 in package net_monitor_pkg.
REQ-032 SHALL implement the synchronizer chain as sub-module net_sync, parameterized by SYNC_STAGES.

Verification (SYNC_STAGES=2, CNT_W=4, STUCK_CYCLES=8)
REQ-033 SHALL cover: rst 1 cycle with din=1 held -> state=0 for 3 cycles, then 1; edge_cnt=0, rise never asserted.
REQ-034 SHALL cover: in TRACK, din 0->1 -> level=1 two edges later, rise=1 for exactly one cycle after that, edge_cnt=1.
REQ-035 SHALL cover: toggle din 20 times slowly -> edge_cnt saturates at 15.
REQ-036 SHALL cover: din held 9 cycles without an edge -> stuck=1, state=2; one din toggle -> stuck=0, state=1, count+1.
REQ-037 SHALL cover: clear asserted in the same cycle as rise -> edge_cnt=0 next cycle.
REQ-038 SHALL cover: expect=0 and din=1 in TRACK -> mismatch=1; rst mid-stream -> all outputs 0, state=0.

Source files
------------

// File: rtl/net_monitor_pkg.sv
// State encoding and shared widths for the net monitor.
`default_nettype none

package net_monitor_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_WARMUP = STATE_W'(0),
        ST_TRACK  = STATE_W'(1),
        ST_STUCK  = STATE_W'(2)
    } state_e;

    // Edge, mismatch and counter updates are live only once warm-up is over.
    function automatic logic is_tracking(input state_e s);
        return (s == ST_TRACK) || (s == ST_STUCK);
    endfunction

endpackage

`default_nettype wire

// File: rtl/net_sync.sv
// Multi-flop synchronizer bringing an asynchronous net into the clk domain.
`default_nettype none

module net_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic level_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din_i};
        end
    end

    assign level_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/net_monitor.sv
// Net monitor: synchronizes din, reports edges, counts them and flags level mismatch.
// Stuck detection (timer, STUCK state, stuck output) is built only with NET_MONITOR_STUCK_EN.
// The expected-level input is named expect_i because "expect" is a reserved word.
`default_nettype none

module net_monitor
    import net_monitor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned STUCK_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               expect_i,
    input  logic               clear,
    output logic               level,
    output logic               rise,
    output logic               fall,
    output logic [CNT_W-1:0]   edge_cnt,
    output logic               mismatch,
    output logic               stuck,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned     WARM_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync
        $error("net_monitor: SYNC_STAGES must be in 2..4");
    end
    if (STUCK_CYCLES < 2) begin : g_bad_stuck
        $error("net_monitor: STUCK_CYCLES must be >= 2");
    end

    state_e              state_q, state_d;
    logic [WARM_W-1:0]   warm_q, warm_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                level_prev_q;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic                mismatch_q, mismatch_d;
    logic                rise_c, fall_c, edge_c, tracking_c;

    net_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .din_i   (din),
        .level_o (level)
    );

    assign rise_c     = level & ~level_prev_q;
    assign fall_c     = ~level & level_prev_q;
    assign edge_c     = rise_c | fall_c;
    assign tracking_c = is_tracking(state_q);

`ifdef NET_MONITOR_STUCK_EN
    localparam int unsigned      TMR_W    = $clog2(STUCK_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STUCK_CYCLES - 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             stuck_q, stuck_d;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WARMUP;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
        end
    end

    // Next-state: warm-up countdown, then tracking with optional stuck detection.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
`ifdef NET_MONITOR_STUCK_EN
        timer_d = timer_q;
`endif
        case (state_q)
            ST_WARMUP: begin
                if (warm_q == WARM_LAST) begin
                    state_d = ST_TRACK;
                    warm_d  = '0;
                end else begin
                    warm_d = warm_q + WARM_W'(1);
                end
            end
            ST_TRACK: begin
`ifdef NET_MONITOR_STUCK_EN
                if (edge_c || clear) begin
                    timer_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    state_d = ST_STUCK;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
`endif
            end
            ST_STUCK: begin
`ifdef NET_MONITOR_STUCK_EN
                if (edge_c || clear) begin
                    state_d = ST_TRACK;
                    timer_d = '0;
                end
`else
                state_d = ST_WARMUP;
`endif
            end
            default: begin
                state_d = ST_WARMUP;
                warm_d  = '0;
`ifdef NET_MONITOR_STUCK_EN
                timer_d = '0;
`endif
            end
        endcase
`ifdef NET_MONITOR_STUCK_EN
        stuck_d = (state_d == ST_STUCK);
`endif
    end

    // Edge pulses, mismatch and the saturating counter; clear beats a same-cycle edge.
    always_comb begin
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        mismatch_d = 1'b0;
        cnt_d      = cnt_q;
        if (tracking_c) begin
            rise_d     = rise_c;
            fall_d     = fall_c;
            mismatch_d = (level != expect_i);
        end
        if (clear) begin
            cnt_d = '0;
        end else if (tracking_c && edge_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_prev_q <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            mismatch_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            level_prev_q <= level;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            mismatch_q   <= mismatch_d;
            cnt_q        <= cnt_d;
        end
    end

`ifdef NET_MONITOR_STUCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            stuck_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            stuck_q <= stuck_d;
        end
    end

    assign stuck = stuck_q;
`else
    assign stuck = 1'b0;
`endif

    assign rise     = rise_q;
    assign fall     = fall_q;
    assign mismatch = mismatch_q;
    assign edge_cnt = cnt_q;
    assign state    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_net_monitor.sv
// Directed bench for net_monitor (SYNC_STAGES=2, CNT_W=4, STUCK_CYCLES=8).
module tb_net_monitor;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             din;
    logic             exp_lvl;
    logic             clear;
    logic             level;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] edge_cnt;
    logic             mismatch;
    logic             stuck;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    net_monitor #(
        .SYNC_STAGES  (2),
        .CNT_W        (CNT_W),
        .STUCK_CYCLES (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .expect_i (exp_lvl),
        .clear    (clear),
        .level    (level),
        .rise     (rise),
        .fall     (fall),
        .edge_cnt (edge_cnt),
        .mismatch (mismatch),
        .stuck    (stuck),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One reset cycle then the three warm-up cycles, leaving the DUT in TRACK.
    task automatic do_reset(input logic d);
        din = d;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        din = 1'b1; exp_lvl = 1'b1; clear = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (edge_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", edge_cnt); end
        checks++; if (level !== 1'b0) begin errors++; $display("FAIL reset_level: got %b want 0", level); end
        checks++; if (stuck !== 1'b0 || mismatch !== 1'b0) begin errors++; $display("FAIL reset_flags: got stuck=%b mismatch=%b want 0 0", stuck, mismatch); end
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++; if (state !== 2'd0) begin errors++; $display("FAIL warmup_state%0d: got %0d want 0", i, state); end
            checks++; if (rise !== 1'b0) begin errors++; $display("FAIL warmup_rise%0d: got %b want 0", i, rise); end
        end
        tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL warmup_exit: got %0d want 1", state); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rise !== 1'b0 || edge_cnt !== 4'd0) begin errors++; $display("FAIL initial_level_counted: got rise=%b cnt=%0d want 0 0", rise, edge_cnt); end
        end
    endtask

    task automatic test_rise();
        exp_lvl = 1'b0;
        do_reset(1'b0);
        din = 1'b1;
        tick();
        checks++; if (level !== 1'b0) begin errors++; $display("FAIL rise_level_early: got %b want 0", level); end
        tick();
        checks++; if (level !== 1'b1 || rise !== 1'b0) begin errors++; $display("FAIL rise_level: got level=%b rise=%b want 1 0", level, rise); end
        tick();
        checks++; if (rise !== 1'b1 || edge_cnt !== 4'd1) begin errors++; $display("FAIL rise_pulse: got rise=%b cnt=%0d want 1 1", rise, edge_cnt); end
        tick();
        checks++; if (rise !== 1'b0 || edge_cnt !== 4'd1 || fall !== 1'b0) begin errors++; $display("FAIL rise_width: got rise=%b fall=%b cnt=%0d want 0 0 1", rise, fall, edge_cnt); end
    endtask

    task automatic test_saturate();
        logic [CNT_W-1:0] want;
        do_reset(1'b0);
        for (int n = 1; n <= 20; n++) begin
            din = ~din;
            repeat (4) tick();
            want = (n > 15) ? 4'd15 : CNT_W'(n);
            if (n == 14 || n == 15 || n == 16 || n == 20) begin
                checks++; if (edge_cnt !== want) begin errors++; $display("FAIL saturate_n%0d: got %0d want %0d", n, edge_cnt, want); end
            end
        end
    endtask

    task automatic test_stuck();
        logic       want_stuck;
        logic [1:0] want_state;
        do_reset(1'b0);
        for (int i = 1; i <= 9; i++) begin
            tick();
`ifdef NET_MONITOR_STUCK_EN
            want_stuck = (i >= 8);
            want_state = (i >= 8) ? 2'd2 : 2'd1;
`else
            want_stuck = 1'b0;
            want_state = 2'd1;
`endif
            if (i >= 6) begin
                checks++; if (stuck !== want_stuck || state !== want_state) begin errors++; $display("FAIL stuck_idle%0d: got stuck=%b state=%0d want %b %0d", i, stuck, state, want_stuck, want_state); end
            end
        end
        din = 1'b1;
        repeat (2) tick();
        checks++; if (state !== want_state) begin errors++; $display("FAIL stuck_hold: got %0d want %0d", state, want_state); end
        tick();
        checks++; if (stuck !== 1'b0 || state !== 2'd1 || edge_cnt !== 4'd1) begin errors++; $display("FAIL stuck_release: got stuck=%b state=%0d cnt=%0d want 0 1 1", stuck, state, edge_cnt); end
    endtask

    task automatic test_clear();
        do_reset(1'b0);
        din = 1'b1;
        repeat (2) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (edge_cnt !== 4'd0 || rise !== 1'b1) begin errors++; $display("FAIL clear_vs_rise: got cnt=%0d rise=%b want 0 1", edge_cnt, rise); end
        din = 1'b0;
        repeat (3) tick();
        checks++; if (edge_cnt !== 4'd1 || fall !== 1'b1) begin errors++; $display("FAIL fall_count: got cnt=%0d fall=%b want 1 1", edge_cnt, fall); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (edge_cnt !== 4'd0 || fall !== 1'b0) begin errors++; $display("FAIL clear_after_fall: got cnt=%0d fall=%b want 0 0", edge_cnt, fall); end
    endtask

    task automatic test_mismatch_reset();
        exp_lvl = 1'b0;
        do_reset(1'b1);
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL mismatch_warmup: got %b want 0", mismatch); end
        tick();
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL mismatch_set: got %b want 1", mismatch); end
        din = 1'b0;
        repeat (3) tick();
        checks++; if (mismatch !== 1'b0 || edge_cnt !== 4'd1) begin errors++; $display("FAIL mismatch_clear: got mismatch=%b cnt=%0d want 0 1", mismatch, edge_cnt); end
        exp_lvl = 1'b1;
        tick();
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL mismatch_expect1: got %b want 1", mismatch); end
        din = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({level, rise, fall, mismatch, stuck} !== 5'b0 || edge_cnt !== 4'd0 || state !== 2'd0) begin
            errors++; $display("FAIL midstream_reset: got lvl=%b r=%b f=%b mm=%b st=%b cnt=%0d state=%0d want all 0", level, rise, fall, mismatch, stuck, edge_cnt, state);
        end
        repeat (2) tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rewarm_state: got %0d want 0", state); end
        tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL rewarm_exit: got %0d want 1", state); end
        repeat (2) tick();
        checks++; if (edge_cnt !== 4'd0 || rise !== 1'b0) begin errors++; $display("FAIL rewarm_no_edge: got cnt=%0d rise=%b want 0 0", edge_cnt, rise); end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_saturate();
        test_stuck();
        test_clear();
        test_mismatch_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
